// File: rtl/aes_col_unit.sv
// AES column step: SubBytes/InvSubBytes, with an optional MixColumns/InvMixColumns
// column contribution, XOR-accumulated into rs1. Handles a single selected byte
// or a full 4-byte column, processing LANES bytes per RUN cycle.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | ready for a request (in_ready=1)
//   RUN    | folding LANES byte contributions per cycle into acc
//   DONE   | result presented on out_rd/out_tag until out_ready
module aes_col_unit #(
   parameter int LANES = 1,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_word,
   input  logic [1:0]       in_bs,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_rd,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   generate
      if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
         $error("aes_col_unit: LANES must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [2:0] STEPS_WORD = 3'(4 / LANES);
   localparam logic [2:0] IDX_INC    = 3'(LANES);

   // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse (and maps 0 to 0, as the S-box wants)
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = a;
      for (int n = 1; n < 8; n++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x;
      x = gf_inv(b);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] y;
      y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(y);
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] i);
      case (i)
         3'd0:    return w[7:0];
         3'd1:    return w[15:8];
         3'd2:    return w[23:16];
         3'd3:    return w[31:24];
         default: return 8'h00;
      endcase
   endfunction

   // op[1] selects decrypt, op[0] selects the mix-column contribution
   function automatic logic [31:0] col_f(input logic [7:0] b, input logic [1:0] op,
                                         input logic [2:0] i);
      logic [7:0]  s;
      logic [31:0] m;
      s = op[1] ? inv_sbox(b) : sbox(b);
      if (!op[0])
         m = {24'h000000, s};
      else if (!op[1])
         m = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
      else
         m = {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
      case (i)
         3'd0:    return m;
         3'd1:    return {m[23:0], m[31:24]};
         3'd2:    return {m[15:0], m[31:16]};
         3'd3:    return {m[7:0],  m[31:8]};
         default: return m;
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               word_q, word_d;
   logic [31:0]        rs2_q, rs2_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [31:0]        acc_q, acc_d;
   logic [2:0]         idx_q, idx_d;
   logic [2:0]         steps_q, steps_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_rd_q, out_rd_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;
   logic               busy_q, busy_d;
   logic [31:0]        lane_x;

   // XOR of this cycle's lane contributions; byte mode only ever uses lane 0
   always_comb begin
      lane_x = 32'h0;
      for (int k = 0; k < LANES; k++) begin
         if (k == 0 || word_q)
            lane_x = lane_x ^ col_f(byte_of(rs2_q, idx_q + 3'(k)), op_q, idx_q + 3'(k));
      end
   end

   // next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      word_d      = word_q;
      rs2_d       = rs2_q;
      tag_d       = tag_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      steps_d     = steps_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_rd_d    = out_rd_q;
      out_tag_d   = out_tag_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d    = S_RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               op_d       = in_op;
               word_d     = in_word;
               rs2_d      = in_rs2;
               tag_d      = in_tag;
               acc_d      = in_rs1;
               idx_d      = in_word ? 3'd0 : {1'b0, in_bs};
               steps_d    = in_word ? STEPS_WORD : 3'd1;
            end
         end
         S_RUN: begin
            acc_d   = acc_q ^ lane_x;
            steps_d = steps_q - 3'd1;
            if (word_q) idx_d = idx_q + IDX_INC;
            if (steps_q == 3'd1) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               out_rd_d    = acc_q ^ lane_x;
               out_tag_d   = tag_q;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   // state registers; reset discards any in-flight request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= 2'b00;
         word_q      <= 1'b0;
         rs2_q       <= 32'h0;
         tag_q       <= '0;
         acc_q       <= 32'h0;
         idx_q       <= 3'd0;
         steps_q     <= 3'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_rd_q    <= 32'h0;
         out_tag_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         word_q      <= word_d;
         rs2_q       <= rs2_d;
         tag_q       <= tag_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         steps_q     <= steps_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_rd_q    <= out_rd_d;
         out_tag_q   <= out_tag_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_rd    = out_rd_q;
   assign out_tag   = out_tag_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes_col_unit.sv
// Scoreboard bench for aes_col_unit: requests push expected results, a monitor
// pops and compares on each output handshake and checks first-valid latency.
module tb_aes_col_unit;
   localparam int LANES = 2;
   localparam int TAG_W = 5;
   localparam logic [1:0] E_FINAL = 2'b00, E_MID = 2'b01, D_FINAL = 2'b10, D_MID = 2'b11;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic             in_word;
   logic [1:0]       in_bs;
   logic [31:0]      in_rs1;
   logic [31:0]      in_rs2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_rd;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   aes_col_unit #(.LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_word(in_word), .in_bs(in_bs),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0]      rd;
      logic [TAG_W-1:0] tag;
      int               acc;
      int               lat;
   } exp_t;

   exp_t       sbq[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[256];
   logic [7:0] isb[256];
   bit         rand_on = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // reference model: GF(2^8) multiply by shift-and-reduce
   function automatic logic [7:0] mgmul(logic [7:0] a, logic [7:0] b);
      int p, x, y;
      p = 0; x = a; y = b;
      while (y != 0) begin
         if (y % 2 == 1) p = p ^ x;
         x = x * 2;
         if (x >= 256) x = x ^ 'h11b;
         y = y / 2;
      end
      return 8'(p);
   endfunction

   function automatic logic [31:0] model_f(logic [7:0] b, logic [1:0] op, int i);
      logic [7:0]  s;
      logic [31:0] m;
      logic [63:0] t;
      s = op[1] ? isb[b] : sb[b];
      if (op[0] == 1'b0)
         m = {24'h0, s};
      else if (op[1] == 1'b0)
         m = {mgmul(s, 8'd3), s, s, mgmul(s, 8'd2)};
      else
         m = {mgmul(s, 8'd11), mgmul(s, 8'd13), mgmul(s, 8'd9), mgmul(s, 8'd14)};
      t = {m, m} << (8 * i);
      return t[63:32];
   endfunction

   function automatic logic [31:0] model_req(logic [1:0] op, logic word, logic [1:0] bs,
                                             logic [31:0] rs1, logic [31:0] rs2);
      logic [31:0] r;
      r = rs1;
      if (word)
         for (int i = 0; i < 4; i++) r = r ^ model_f(rs2[8*i +: 8], op, i);
      else
         r = r ^ model_f(rs2[8*bs +: 8], op, int'(bs));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(logic [1:0] op, logic word, logic [1:0] bs, logic [31:0] rs1,
                       logic [31:0] rs2, logic [TAG_W-1:0] tag, logic [31:0] exp_rd,
                       output int acc);
      int n;
      in_op = op; in_word = word; in_bs = bs; in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         acc = -1;
         in_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      sbq.push_back('{rd: exp_rd, tag: tag, acc: acc, lat: (word ? 1 + 4 / LANES : 2)});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !in_ready) && n < 500) begin
         tick();
         n++;
      end
      chk("drain_pending", 32'(sbq.size()), 32'd0);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("wait_out_valid", 32'(out_valid), 32'd1);
   endtask

   // monitor: latency on first valid cycle, data/tag on handshake
   bit   prev_ov = 1'b0;
   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_ov) begin
            if (sbq.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
            else chk("latency", 32'(cyc - sbq[0].acc + 1), 32'(sbq[0].lat));
         end
         if (out_valid && out_ready && sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("out_rd", out_rd, mon_e.rd);
            chk("out_tag", 32'(out_tag), 32'(mon_e.tag));
         end
      end
      prev_ov <= out_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  v, o, c;
      logic [31:0] e, eb;
      logic [1:0]  rop, rbs;
      logic        rword;
      logic [31:0] r1, r2;
      int          a, hs;

      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         v = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (mgmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         for (int i = 0; i < 8; i++)
            o[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
         sb[x]  = o;
         isb[o] = 8'(x);
      end

      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0; in_bs = 2'b00;
      in_rs1 = 32'h0; in_rs2 = 32'h0; in_tag = '0; out_ready = 1'b1;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_rd", out_rd, 32'h0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // directed vectors with known answers
      send(E_FINAL, 1'b0, 2'd0, 32'h0, 32'h0, 5'h03, 32'h00000063, a);
      send(E_FINAL, 1'b0, 2'd2, 32'h11111111, 32'h00530000, 5'h0a, 32'h11FC1111, a);
      send(E_MID, 1'b0, 2'd0, 32'h0, 32'h0, 5'h01, 32'hA56363C6, a);
      send(E_MID, 1'b0, 2'd1, 32'h0, 32'h0, 5'h02, 32'h6363C6A5, a);
      send(E_MID, 1'b1, 2'd3, 32'h0, 32'h0, 5'h04, 32'h63636363, a);
      send(D_FINAL, 1'b1, 2'd1, 32'h0, 32'h63636363, 5'h05, 32'h00000000, a);
      send(D_FINAL, 1'b1, 2'd0, 32'h0, 32'h0, 5'h06, 32'h52525252, a);
      send(D_MID, 1'b0, 2'd3, 32'hDEADBEEF, 32'h12345678, 5'h07,
           model_req(D_MID, 1'b0, 2'd3, 32'hDEADBEEF, 32'h12345678), a);
      send(D_MID, 1'b1, 2'd0, 32'hCAFEF00D, 32'h89ABCDEF, 5'h08,
           model_req(D_MID, 1'b1, 2'd0, 32'hCAFEF00D, 32'h89ABCDEF), a);
      drain();

      // backpressure: hold result 5 cycles while a new request waits
      out_ready = 1'b0;
      e = model_req(E_MID, 1'b1, 2'd0, 32'h01020304, 32'hA1B2C3D4);
      send(E_MID, 1'b1, 2'd0, 32'h01020304, 32'hA1B2C3D4, 5'h15, e, a);
      wait_valid();
      eb = model_req(D_FINAL, 1'b0, 2'd1, 32'h0F0F0F0F, 32'h00001200);
      in_op = D_FINAL; in_word = 1'b0; in_bs = 2'd1; in_rs1 = 32'h0F0F0F0F;
      in_rs2 = 32'h00001200; in_tag = 5'h1c; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_rd", out_rd, e);
         chk("bp_out_tag", 32'(out_tag), 32'h15);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      hs = cyc + 1;
      send(D_FINAL, 1'b0, 2'd1, 32'h0F0F0F0F, 32'h00001200, 5'h1c, eb, a);
      chk("accept_after_handshake", 32'(a), 32'(hs + 1));
      drain();

      // reset in the middle of RUN
      send(E_MID, 1'b1, 2'd0, 32'hFFFF0000, 32'h13579BDF, 5'h09,
           model_req(E_MID, 1'b1, 2'd0, 32'hFFFF0000, 32'h13579BDF), a);
      rst = 1'b1;
      #1;
      chk("rst_run_out_valid", 32'(out_valid), 32'd0);
      chk("rst_run_in_ready", 32'(in_ready), 32'd1);
      chk("rst_run_busy", 32'(busy), 32'd0);
      sbq.delete();
      tick();
      rst = 1'b0;
      tick();
      send(E_FINAL, 1'b1, 2'd0, 32'h0, 32'h0, 5'h0b, 32'h63636363, a);
      drain();

      // reset while a result is waiting in DONE
      out_ready = 1'b0;
      send(E_FINAL, 1'b0, 2'd1, 32'h0, 32'h00005300, 5'h0c, 32'h0000ED00, a);
      wait_valid();
      rst = 1'b1;
      #1;
      chk("rst_done_out_valid", 32'(out_valid), 32'd0);
      sbq.delete();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // randomized traffic with random output backpressure
      rand_on = 1'b1;
      fork
         begin
            while (rand_on) begin
               @(posedge clk);
               #3;
               if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int n = 0; n < 150; n++) begin
         rop   = 2'($urandom_range(0, 3));
         rword = 1'($urandom_range(0, 1));
         rbs   = 2'($urandom_range(0, 3));
         r1    = $urandom;
         r2    = $urandom;
         send(rop, rword, rbs, r1, r2, TAG_W'($urandom_range(0, 31)),
              model_req(rop, rword, rbs, r1, r2), a);
      end
      rand_on = 1'b0;
      tick(); tick();
      out_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
